// File: rtl/apb_prio_intc.sv
// apb_prio_intc: APB-programmable priority interrupt controller.
// Per-source priority, mask and edge/level mode; pending register with
// write-1-to-clear for edge sources; a three-state arbiter presents one
// winner (id + priority) and holds it until the CPU signals service.
module apb_prio_intc #(
  parameter int PERIPHERALS = 16,
  parameter int PRIO_W      = 4,
  parameter int DATA_W      = 32,
  parameter int ID_W        = $clog2(PERIPHERALS),
  parameter int ADDR_W      = $clog2(PERIPHERALS + 3)
) (
  input  logic                   pclk,
  input  logic                   prst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwr_rd_en,
  input  logic [ADDR_W-1:0]      paddr,
  input  logic [DATA_W-1:0]      pwdata,
  output logic [DATA_W-1:0]      prdata,
  output logic                   pready,
  output logic                   perror,
  input  logic [PERIPHERALS-1:0] interrupt_active,
  input  logic                   interrupt_serviced,
  output logic [ID_W-1:0]        interrupt_to_service,
  output logic [PRIO_W-1:0]      interrupt_priority,
  output logic                   interrupt_valid
);

  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(PERIPHERALS);
  localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(PERIPHERALS + 1);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(PERIPHERALS + 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ARB  = 3'b010,
    S_WAIT = 3'b100
  } state_t;

  // Register file and status
  logic [PERIPHERALS-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [PERIPHERALS-1:0]             mask_q, mask_d;
  logic [PERIPHERALS-1:0]             mode_q, mode_d;
  logic [PERIPHERALS-1:0]             pend_q, pend_d;
  logic [PERIPHERALS-1:0]             prev_q, prev_d;

  // Arbiter state and registered outputs
  state_t                             state_q, state_d;
  logic [ID_W-1:0]                    id_q, id_d;
  logic [PRIO_W-1:0]                  prio_out_q, prio_out_d;
  logic                               valid_q, valid_d;

  logic                               addr_oob;
  logic                               wr_en;
  logic                               rd_en;
  logic [PERIPHERALS-1:0]             w1c;
  logic [PERIPHERALS-1:0]             svc_clr;
  logic                               svc_fire;
  logic [PERIPHERALS-1:0]             prio_nz;
  logic [PERIPHERALS-1:0]             eligible;
  logic [PERIPHERALS-1:0]             elig_next;
  logic [ID_W-1:0]                    win_id;
  logic [PRIO_W-1:0]                  win_prio;
  logic                               unused_pwdata;

  // Upper write-data bits have no destination in any register.
  assign unused_pwdata = ^pwdata;

  // APB handshake: zero wait states, error on addresses past MODE.
  assign pready   = psel & penable;
  assign addr_oob = (paddr > A_MODE);
  assign perror   = pready & addr_oob;
  assign wr_en    = pready & pwr_rd_en & ~addr_oob;
  assign rd_en    = pready & ~pwr_rd_en;

  assign svc_fire = (state_q == S_WAIT) & interrupt_serviced;

  // Combinational read mux; out-of-range and idle bus read as zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    prdata = '0;
    if (rd_en) begin
      for (int i = 0; i < PERIPHERALS; i++) begin
        if (paddr == ADDR_W'(i)) prdata[PRIO_W-1:0] = prio_q[i];
      end
      if (paddr == A_MASK) prdata[PERIPHERALS-1:0] = mask_q;
      if (paddr == A_PEND) prdata[PERIPHERALS-1:0] = pend_q;
      if (paddr == A_MODE) prdata[PERIPHERALS-1:0] = mode_q;
    end
  end

  // Register writes commit at the edge ending the access phase.
  always_comb begin
    prio_d = prio_q;
    mask_d = mask_q;
    mode_d = mode_q;
    w1c    = '0;
    if (wr_en) begin
      for (int i = 0; i < PERIPHERALS; i++) begin
        if (paddr == ADDR_W'(i)) prio_d[i] = pwdata[PRIO_W-1:0];
      end
      if (paddr == A_MASK) mask_d = pwdata[PERIPHERALS-1:0];
      if (paddr == A_PEND) w1c    = pwdata[PERIPHERALS-1:0];
      if (paddr == A_MODE) mode_d = pwdata[PERIPHERALS-1:0];
    end
  end

  // Pending: level sources track the input; edge sources latch rising edges,
  // and a fresh edge beats a simultaneous W1C or service clear.
  always_comb begin
    prev_d = interrupt_active;
    for (int i = 0; i < PERIPHERALS; i++) begin
      svc_clr[i] = svc_fire & (id_q == ID_W'(i));
      prio_nz[i] = |prio_q[i];
      if (mode_q[i]) begin
        pend_d[i] = (pend_q[i] & ~(w1c[i] | svc_clr[i])) |
                    (interrupt_active[i] & ~prev_q[i]);
      end else begin
        pend_d[i] = interrupt_active[i];
      end
    end
    eligible  = pend_q & mask_q & prio_nz;
    elig_next = pend_d & mask_q & prio_nz;
  end

  // Winner search: strict compare keeps the lowest index on a priority tie.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < PERIPHERALS; i++) begin
      if (eligible[i] && (prio_q[i] > win_prio)) begin
        win_id   = ID_W'(i);
        win_prio = prio_q[i];
      end
    end
  end

  // Arbiter next state: idle -> arbitrate -> hold winner until serviced.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    prio_out_d = prio_out_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible) state_d = S_ARB;
      end
      S_ARB: begin
        if (|eligible) begin
          id_d       = win_id;
          prio_out_d = win_prio;
          valid_d    = 1'b1;
          state_d    = S_WAIT;
        end else begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Outputs stay frozen here regardless of mask/input changes.
        if (interrupt_serviced) begin
          valid_d    = 1'b0;
          id_d       = '0;
          prio_out_d = '0;
          state_d    = (|elig_next) ? S_ARB : S_IDLE;
        end
      end
      default: begin
        valid_d    = 1'b0;
        id_d       = '0;
        prio_out_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // All state with synchronous reset.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (prst) begin
      // NOTE: the priority array is a handful of flops, not a RAM, so it is cleared on reset like everything else.
      prio_q     <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      state_q    <= S_IDLE;
      id_q       <= '0;
      prio_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      id_q       <= id_d;
      prio_out_q <= prio_out_d;
      valid_q    <= valid_d;
    end
  end

  assign interrupt_to_service = id_q;
  assign interrupt_priority   = prio_out_q;
  assign interrupt_valid      = valid_q;

endmodule

// File: tb/tb_apb_prio_intc.sv
// tb_apb_prio_intc: directed bench for apb_prio_intc with a register
// vector table plus hand-written arbitration and pending sequences.
module tb_apb_prio_intc;

  localparam int N      = 16;
  localparam int PRIO_W = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] A_MASK = 5'd16;
  localparam logic [ADDR_W-1:0] A_PEND = 5'd17;
  localparam logic [ADDR_W-1:0] A_MODE = 5'd18;

  logic              pclk = 1'b0;
  logic              prst;
  logic              psel;
  logic              penable;
  logic              pwr_rd_en;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              perror;
  logic [N-1:0]      interrupt_active;
  logic              interrupt_serviced;
  logic [ID_W-1:0]   interrupt_to_service;
  logic [PRIO_W-1:0] interrupt_priority;
  logic              interrupt_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[$];

  apb_prio_intc #(
    .PERIPHERALS(N), .PRIO_W(PRIO_W), .DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W)
  ) dut (
    .pclk                (pclk),
    .prst                (prst),
    .psel                (psel),
    .penable             (penable),
    .pwr_rd_en           (pwr_rd_en),
    .paddr               (paddr),
    .pwdata              (pwdata),
    .prdata              (prdata),
    .pready              (pready),
    .perror              (perror),
    .interrupt_active    (interrupt_active),
    .interrupt_serviced  (interrupt_serviced),
    .interrupt_to_service(interrupt_to_service),
    .interrupt_priority  (interrupt_priority),
    .interrupt_valid     (interrupt_valid)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge with the bus idle.
  task automatic do_reset();
    prst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwr_rd_en = 1'b0; paddr = '0; pwdata = '0;
    interrupt_active = '0; interrupt_serviced = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b0;
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    psel = 1'b1; penable = 1'b0; pwr_rd_en = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwr_rd_en = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                          output logic rdy, output logic err);
    psel = 1'b1; penable = 1'b0; pwr_rd_en = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d = prdata; rdy = pready; err = perror;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    logic [DATA_W-1:0] d;
    logic rdy, err;
    apb_read(a, d, rdy, err);
    check(name, d, exp);
  endtask

  task automatic pulse_service();
    interrupt_serviced = 1'b1;
    @(negedge pclk);
    interrupt_serviced = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!interrupt_valid && k < budget) begin
      @(negedge pclk);
      k++;
    end
    check(name, {31'd0, interrupt_valid}, 32'd1);
  endtask

  task automatic check_out(input string name, input logic v, input logic [ID_W-1:0] id,
                           input logic [PRIO_W-1:0] pr);
    check({name, "_valid"}, {31'd0, interrupt_valid}, {31'd0, v});
    check({name, "_id"}, {28'd0, interrupt_to_service}, {28'd0, id});
    check({name, "_prio"}, {28'd0, interrupt_priority}, {28'd0, pr});
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic rdy, err;

    // Register vector table: reset values, then write/readback behaviour.
    for (int a = 0; a <= N + 2; a++) vecs.push_back('{1'b0, ADDR_W'(a), 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 5'd19, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 5'd31, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 5'd3,   32'hFFFF_FFF5, 32'h0000_0005, 1'b0});
    vecs.push_back('{1'b1, 5'd15,  32'h0000_000A, 32'h0000_000A, 1'b0});
    vecs.push_back('{1'b1, A_MASK, 32'hFFFF_1234, 32'h0000_1234, 1'b0});
    vecs.push_back('{1'b1, A_MODE, 32'hABCD_8001, 32'h0000_8001, 1'b0});
    vecs.push_back('{1'b1, A_PEND, 32'h0000_FFFF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 5'd19,  32'h0000_0005, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 5'd0,   32'h0,         32'h0000_0000, 1'b0});

    do_reset();
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check_out("rst_out", 1'b0, '0, '0);

    foreach (vecs[v]) begin
      if (vecs[v].wr) apb_write(vecs[v].addr, vecs[v].wdata);
      apb_read(vecs[v].addr, d, rdy, err);
      check($sformatf("vec%0d_rdata", v), d, vecs[v].exp_rdata);
      check($sformatf("vec%0d_pready", v), {31'd0, rdy}, 32'd1);
      check($sformatf("vec%0d_perror", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
    end

    // Level mode: two sources, latency, highest priority wins, no preemption.
    do_reset();
    apb_write(5'd3, 32'd5);
    apb_write(5'd7, 32'd9);
    apb_write(A_MASK, 32'h0088);
    interrupt_active = 16'h0088;
    @(negedge pclk);
    @(negedge pclk);
    check("lat_s1_valid", {31'd0, interrupt_valid}, 32'd0);
    @(negedge pclk);
    check_out("lvl_win7", 1'b1, 4'd7, 4'd9);
    interrupt_active = 16'h0008;
    @(negedge pclk);
    check_out("lvl_hold7", 1'b1, 4'd7, 4'd9);
    pulse_service();
    check_out("lvl_svc7", 1'b0, 4'd0, 4'd0);
    @(negedge pclk);
    check_out("lvl_win3", 1'b1, 4'd3, 4'd5);
    interrupt_active = 16'h0088;
    repeat (4) @(negedge pclk);
    check_out("no_preempt", 1'b1, 4'd3, 4'd5);
    pulse_service();
    @(negedge pclk);
    check_out("lvl_after_pre", 1'b1, 4'd7, 4'd9);
    interrupt_active = '0;
    repeat (2) @(negedge pclk);
    pulse_service();
    repeat (3) @(negedge pclk);
    check("lvl_idle_valid", {31'd0, interrupt_valid}, 32'd0);

    // Priority tie goes to the lower index, repeatedly while both stay high.
    do_reset();
    apb_write(5'd2, 32'd6);
    apb_write(5'd9, 32'd6);
    apb_write(A_MASK, 32'h0204);
    interrupt_active = 16'h0204;
    wait_valid("tie_wait", 10);
    check_out("tie_win", 1'b1, 4'd2, 4'd6);
    pulse_service();
    check("tie_svc_valid", {31'd0, interrupt_valid}, 32'd0);
    @(negedge pclk);
    check_out("tie_again", 1'b1, 4'd2, 4'd6);

    // Edge mode: single pulse latches, service clears; W1C vs new edge.
    do_reset();
    apb_write(5'd5, 32'd1);
    apb_write(A_MASK, 32'h0020);
    apb_write(A_MODE, 32'h0020);
    interrupt_active = 16'h0020;
    @(negedge pclk);
    interrupt_active = '0;
    read_check("edge_pend_set", A_PEND, 32'h20);
    check_out("edge_win", 1'b1, 4'd5, 4'd1);
    pulse_service();
    check_out("edge_svc", 1'b0, 4'd0, 4'd0);
    read_check("edge_pend_clr", A_PEND, 32'h0);
    check("edge_idle_valid", {31'd0, interrupt_valid}, 32'd0);
    apb_write(A_MASK, 32'h0);
    psel = 1'b1; penable = 1'b0; pwr_rd_en = 1'b1; paddr = A_PEND; pwdata = 32'h20;
    @(negedge pclk);
    penable = 1'b1;
    interrupt_active = 16'h0020;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwr_rd_en = 1'b0;
    read_check("w1c_edge_wins", A_PEND, 32'h20);
    apb_write(A_PEND, 32'h20);
    read_check("w1c_held_clr", A_PEND, 32'h0);
    interrupt_active = '0;

    // Mask / zero priority suppress; masking the winner does not disturb it.
    do_reset();
    apb_write(5'd4, 32'd3);
    interrupt_active = 16'h0010;
    repeat (5) @(negedge pclk);
    check("masked_no_valid", {31'd0, interrupt_valid}, 32'd0);
    apb_write(5'd4, 32'd0);
    apb_write(A_MASK, 32'h0010);
    repeat (5) @(negedge pclk);
    check("prio0_no_valid", {31'd0, interrupt_valid}, 32'd0);
    apb_write(5'd4, 32'd3);
    wait_valid("mask_wait", 10);
    check_out("mask_win", 1'b1, 4'd4, 4'd3);
    apb_write(A_MASK, 32'h0);
    interrupt_active = '0;
    repeat (3) @(negedge pclk);
    check_out("mask_hold", 1'b1, 4'd4, 4'd3);
    pulse_service();
    check_out("mask_svc", 1'b0, 4'd0, 4'd0);
    repeat (3) @(negedge pclk);
    check("mask_stay_idle", {31'd0, interrupt_valid}, 32'd0);

    // Reset while a winner is held; service pulse ignored when idle.
    do_reset();
    apb_write(5'd1, 32'd2);
    apb_write(A_MASK, 32'h0002);
    apb_write(A_MODE, 32'h0002);
    interrupt_active = 16'h0002;
    @(negedge pclk);
    interrupt_active = '0;
    wait_valid("rst_mid_wait", 10);
    check_out("rst_mid_win", 1'b1, 4'd1, 4'd2);
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    check_out("rst_mid_out", 1'b0, 4'd0, 4'd0);
    read_check("rst_mid_pend", A_PEND, 32'h0);
    read_check("rst_mid_prio1", 5'd1, 32'h0);
    apb_write(A_MODE, 32'h0001);
    interrupt_active = 16'h0001;
    @(negedge pclk);
    interrupt_active = '0;
    pulse_service();
    read_check("idle_svc_ignored", A_PEND, 32'h1);
    check("idle_svc_valid", {31'd0, interrupt_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
